// File: rtl/fifo_word_splitter.sv
// Write-side feeder for the async FIFO. Wide words (up to RATIO entries) arrive
// on a valid/ready stream and leave as one DSIZE-bit FIFO write per wclk cycle.
// winc and wdata come straight from flops. The only combinational
// input-to-output path is wfull -> in_ready, which lets a new word load on the
// same edge as the previous word's last write.
module fifo_word_splitter #(
  parameter int DSIZE = 8,
  parameter int RATIO = 4,
  parameter int NBW   = 3
) (
  input  logic                   wclk,
  input  logic                   rst,
  input  logic [DSIZE*RATIO-1:0] in_data,
  input  logic [NBW-1:0]         in_nbytes,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DSIZE-1:0]       wdata,
  output logic                   winc,
  input  logic                   wfull,
  output logic                   err,
  output logic [15:0]            wr_count
);

  localparam int IW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [NBW-1:0] RATIO_N = NBW'(RATIO);
  localparam logic [NBW-1:0] ONE_N   = NBW'(1);

  logic                        busy;
  logic [RATIO-1:0][DSIZE-1:0] hold;
  logic [IW-1:0]               idx;
  logic [NBW-1:0]              rem;
  logic [DSIZE-1:0]            wdata_q;

  logic [RATIO-1:0][DSIZE-1:0] in_words;
  logic                        last, fire, accept, over, load;
  logic [NBW-1:0]              n_eff;
  logic [IW-1:0]               idx_nx;

  // Entry k of the input word sits at in_data[k*DSIZE +: DSIZE].
  assign in_words = in_data;

  assign last     = (rem == ONE_N);
  assign fire     = busy && !wfull;
  assign in_ready = !rst && (!busy || (last && !wfull));
  assign accept   = in_valid && in_ready;
  assign over     = (in_nbytes > RATIO_N);
  assign n_eff    = over ? RATIO_N : in_nbytes;
  // A zero-length word is consumed but never loads anything.
  assign load     = accept && (n_eff != '0);
  assign idx_nx   = idx + IW'(1);

  assign winc  = busy;
  assign wdata = wdata_q;

  // Word capture and per-entry advance. A load wins over the last-entry
  // retire so back-to-back words keep winc high without a bubble.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      hold    <= '0;
      idx     <= '0;
      rem     <= '0;
      wdata_q <= '0;
    end else if (load) begin
      busy    <= 1'b1;
      hold    <= in_words;
      idx     <= '0;
      rem     <= n_eff;
      wdata_q <= in_words[0];
    end else if (fire) begin
      if (!last) begin
        idx     <= idx_nx;
        rem     <= rem - ONE_N;
        wdata_q <= hold[idx_nx];
      end else begin
        // wdata keeps the final entry while idle.
        busy <= 1'b0;
        idx  <= '0;
        rem  <= '0;
      end
    end
  end

  // Sticky oversize flag: set once any word claiming more than RATIO entries is taken.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst)              err <= 1'b0;
    else if (accept && over) err <= 1'b1;
  end

  // Completed-write counter, free-running modulo 2^16.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst)       wr_count <= '0;
    else if (fire) wr_count <= wr_count + 16'd1;
  end

endmodule

// File: tb/tb_fifo_word_splitter.sv
// Bench for fifo_word_splitter: directed per-cycle vector table, randomized
// traffic against a queue-based reference model, and a counter-wrap sequence.
module tb_fifo_word_splitter;

  logic        wclk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [2:0]  in_nbytes;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  wdata;
  logic        winc;
  logic        wfull;
  logic        err;
  logic [15:0] wr_count;

  int nchk = 0;
  int nerr = 0;

  fifo_word_splitter #(.DSIZE(8), .RATIO(4), .NBW(3)) dut (
    .wclk(wclk), .rst(rst), .in_data(in_data), .in_nbytes(in_nbytes),
    .in_valid(in_valid), .in_ready(in_ready), .wdata(wdata), .winc(winc),
    .wfull(wfull), .err(err), .wr_count(wr_count)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      if (nerr <= 20) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  // Reference model: every accepted word appends its (clamped) entries to a
  // queue; the FIFO is written whenever the queue holds data and wfull is low.
  logic [7:0] mq[$];
  int         mcount;
  logic       merr;

  always @(negedge wclk) begin
    int k;
    if (rst) begin
      mq.delete();
      mcount = 0;
      merr   = 1'b0;
      chk("rst_winc",  winc,     0);
      chk("rst_ready", in_ready, 0);
      chk("rst_wdata", wdata,    0);
      chk("rst_cnt",   wr_count, 0);
      chk("rst_err",   err,      0);
    end else begin
      chk("m_winc",  winc,     mq.size() != 0);
      chk("m_ready", in_ready, (mq.size() == 0) || (mq.size() == 1 && !wfull));
      chk("m_cnt",   wr_count, mcount % 65536);
      chk("m_err",   err,      merr);
      if (mq.size() != 0) chk("m_wdata", wdata, mq[0]);
      if (mq.size() != 0 && !wfull) begin
        void'(mq.pop_front());
        mcount++;
      end
      if (in_valid && in_ready) begin
        k = (in_nbytes > 3'd4) ? 4 : int'(in_nbytes);
        for (int j = 0; j < k; j++) mq.push_back(in_data[j*8 +: 8]);
        if (in_nbytes > 3'd4) merr = 1'b1;
      end
    end
  end

  typedef struct {
    logic        r, v;
    logic [31:0] d;
    logic [2:0]  n;
    logic        f;
    logic        ew;
    logic [7:0]  ed;
    logic        er;
    logic [15:0] ec;
    logic        ee;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic [31:0] d,
                              input logic [2:0] n, input logic f, input logic ew,
                              input logic [7:0] ed, input logic er,
                              input logic [15:0] ec, input logic ee);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.n = n; x.f = f;
    x.ew = ew; x.ed = ed; x.er = er; x.ec = ec; x.ee = ee;
    return x;
  endfunction

  task automatic send_word(input logic [31:0] d, input logic [2:0] n);
    logic acc;
    int   t;
    in_valid  = 1'b1;
    in_data   = d;
    in_nbytes = n;
    acc = 1'b0;
    for (t = 0; t < 20 && !acc; t++) begin
      @(negedge wclk);
      acc = in_ready;
      tick();
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name, input logic [15:0] exp_cnt);
    int t;
    for (t = 0; t < 20; t++) begin
      @(negedge wclk);
      if (!winc) break;
      tick();
    end
    chk({name, "_drain"}, t < 20, 1);
    chk(name, wr_count, exp_cnt);
    tick();
  endtask

  vec_t tbl[$];

  initial begin
    logic acc;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_nbytes = '0; wfull = 1'b0;

    // rst v data n f | winc wdata rdy cnt err
    tbl.push_back(mk(1,0,32'h0,0,0, 0,8'h00,0,0,0));
    // single 4-entry word
    tbl.push_back(mk(0,1,32'h44332211,4,0, 0,8'h00,1,0,0));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,8'h11,0,0,0));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,8'h22,0,1,0));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,8'h33,0,2,0));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,8'h44,1,3,0));
    tbl.push_back(mk(0,0,32'h0,0,0, 0,8'h44,1,4,0));
    // back-to-back words, no bubble
    tbl.push_back(mk(1,0,32'h0,0,0, 0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,32'hDDCCBBAA,4,0, 0,8'h00,1,0,0));
    tbl.push_back(mk(0,1,32'h00000099,1,0, 1,8'hAA,0,0,0));
    tbl.push_back(mk(0,1,32'h00000099,1,0, 1,8'hBB,0,1,0));
    tbl.push_back(mk(0,1,32'h00000099,1,0, 1,8'hCC,0,2,0));
    tbl.push_back(mk(0,1,32'h00000099,1,0, 1,8'hDD,1,3,0));
    tbl.push_back(mk(0,1,32'h87654321,2,0, 1,8'h99,1,4,0));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,8'h21,0,5,0));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,8'h43,1,6,0));
    tbl.push_back(mk(0,0,32'h0,0,0, 0,8'h43,1,7,0));
    // backpressure: wfull for 5 cycles while 0x22 is presented
    tbl.push_back(mk(1,0,32'h0,0,0, 0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,32'h44332211,4,0, 0,8'h00,1,0,0));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,8'h11,0,0,0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,32'h0,0,1, 1,8'h22,0,1,0));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,8'h22,0,1,0));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,8'h33,0,2,0));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,8'h44,1,3,0));
    tbl.push_back(mk(0,0,32'h0,0,0, 0,8'h44,1,4,0));
    // n=0 dropped, then oversize n=7 clamps to 4 and sets err
    tbl.push_back(mk(0,1,32'h000000FF,0,0, 0,8'h44,1,4,0));
    tbl.push_back(mk(0,0,32'h0,0,0, 0,8'h44,1,4,0));
    tbl.push_back(mk(0,1,32'h0D0C0B0A,7,0, 0,8'h44,1,4,0));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,8'h0A,0,4,1));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,8'h0B,0,5,1));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,8'h0C,0,6,1));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,8'h0D,1,7,1));
    tbl.push_back(mk(0,0,32'h0,0,0, 0,8'h0D,1,8,1));
    // reset mid-word, then a single-entry word
    tbl.push_back(mk(0,1,32'h44332211,4,0, 0,8'h0D,1,8,1));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,8'h11,0,8,1));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,8'h22,0,9,1));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,8'h33,0,10,1));
    tbl.push_back(mk(1,0,32'h0,0,0, 0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,32'h0000005A,1,0, 0,8'h00,1,0,0));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,8'h5A,1,0,0));
    tbl.push_back(mk(0,0,32'h0,0,0, 0,8'h5A,1,1,0));
    tbl.push_back(mk(0,0,32'h0,0,0, 0,8'h5A,1,1,0));

    tick();
    foreach (tbl[i]) begin
      rst = tbl[i].r; in_valid = tbl[i].v; in_data = tbl[i].d;
      in_nbytes = tbl[i].n; wfull = tbl[i].f;
      @(negedge wclk);
      chk($sformatf("v%0d_winc", i),  winc,     tbl[i].ew);
      chk($sformatf("v%0d_wdata", i), wdata,    tbl[i].ed);
      chk($sformatf("v%0d_ready", i), in_ready, tbl[i].er);
      chk($sformatf("v%0d_cnt", i),   wr_count, tbl[i].ec);
      chk($sformatf("v%0d_err", i),   err,      tbl[i].ee);
      tick();
    end

    // randomized traffic, valid held until accepted, one reset in the middle
    rst = 1'b0; in_valid = 1'b0; acc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst = (c == 1500);
      if (!in_valid || acc) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = $urandom;
        in_nbytes = ($urandom_range(0, 15) == 0) ? 3'(5 + $urandom_range(0, 2))
                                                 : 3'($urandom_range(0, 4));
      end
      wfull = ($urandom_range(0, 3) == 0);
      @(negedge wclk);
      acc = in_valid && in_ready;
      tick();
    end

    // counter wrap: 0xFFFE writes, then a 3-entry word lands on 0x0001
    in_valid = 1'b0; wfull = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int w = 0; w < 16383; w++) send_word($urandom, 3'd4);
    send_word(32'h00000102, 3'd2);
    drain("cnt_fffe", 16'hFFFE);
    send_word(32'h00030201, 3'd3);
    drain("cnt_wrap", 16'h0001);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
